// File: rtl/div_issue_ctrl.sv
// Issue controller for the signed/unsigned AXI-stream divider IPs: latches one op,
// handshakes each IP input channel independently, returns the result, drains on flush.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_mod,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        s_dividend_tvalid,
  output logic        s_divisor_tvalid,
  input  logic        s_dividend_tready,
  input  logic        s_divisor_tready,
  output logic        u_dividend_tvalid,
  output logic        u_divisor_tvalid,
  input  logic        u_dividend_tready,
  input  logic        u_divisor_tready,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        s_dout_valid,
  input  logic [63:0] s_dout,
  input  logic        u_dout_valid,
  input  logic [63:0] u_dout,
  output logic        timeout,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on any rising edge where valid and ready are both 1;
  // valid, once raised, stays high until that transfer (or until a flush cancels it).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               sel_signed, sel_mod;
  logic               dvd_acc, dvs_acc, cancel;
  logic               dvd_acc_nxt, dvs_acc_nxt, cancel_nxt;
  logic               load_op, capture;
  logic [CNT_W-1:0]   cnt;
  logic               dvd_tv, dvs_tv, dvd_done, dvs_done, dout_v;
  logic [63:0]        dout_sel;
  logic               in_wait, nxt_wait;

  // Channel valids are pure decodes of state and acceptance flags.
  always_comb begin
    dvd_tv            = (state == S_ISSUE) && !dvd_acc;
    dvs_tv            = (state == S_ISSUE) && !dvs_acc;
    s_dividend_tvalid = dvd_tv && sel_signed;
    s_divisor_tvalid  = dvs_tv && sel_signed;
    u_dividend_tvalid = dvd_tv && !sel_signed;
    u_divisor_tvalid  = dvs_tv && !sel_signed;
    dvd_done = dvd_acc || (dvd_tv && (sel_signed ? s_dividend_tready : u_dividend_tready));
    dvs_done = dvs_acc || (dvs_tv && (sel_signed ? s_divisor_tready : u_divisor_tready));
    dout_v   = sel_signed ? s_dout_valid : u_dout_valid;
    dout_sel = sel_signed ? s_dout : u_dout;
  end

  always_comb begin
    state_nxt   = state;
    load_op     = 1'b0;
    capture     = 1'b0;
    dvd_acc_nxt = dvd_acc;
    dvs_acc_nxt = dvs_acc;
    cancel_nxt  = cancel;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          load_op     = 1'b1;
          dvd_acc_nxt = 1'b0;
          dvs_acc_nxt = 1'b0;
          cancel_nxt  = 1'b0;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dvd_acc_nxt = dvd_done;
        dvs_acc_nxt = dvs_done;
        // Once any channel is in, the other must follow or the IP wedges.
        if (flush && !dvd_done && !dvs_done) begin
          state_nxt = S_IDLE;
        end else begin
          cancel_nxt = cancel || flush;
          if (dvd_done && dvs_done) state_nxt = (cancel || flush) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nxt = dout_v ? S_IDLE : S_DRAIN;
        end else if (dout_v) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        if (dout_v) state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (flush || res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_wait  = (state == S_WAIT) || (state == S_DRAIN);
  assign nxt_wait = (state_nxt == S_WAIT) || (state_nxt == S_DRAIN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      sel_signed   <= 1'b0;
      sel_mod      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      dvd_acc      <= 1'b0;
      dvs_acc      <= 1'b0;
      cancel       <= 1'b0;
      res_data     <= '0;
      cnt          <= '0;
      timeout      <= 1'b0;
    end else begin
      state   <= state_nxt;
      dvd_acc <= dvd_acc_nxt;
      dvs_acc <= dvs_acc_nxt;
      cancel  <= cancel_nxt;
      if (load_op) begin
        sel_signed   <= req_signed;
        sel_mod      <= req_mod;
        div_dividend <= req_src1;
        div_divisor  <= req_src2;
      end
      if (capture) res_data <= sel_mod ? dout_sel[31:0] : dout_sel[63:32];
      if (nxt_wait && (state_nxt != state)) begin
        cnt <= '0;
      end else if (in_wait && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
      // Sticky diagnostic only; the FSM keeps waiting for the IP.
      if (in_wait && (cnt >= CNT_W'(TIMEOUT_CYC))) timeout <= 1'b1;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences one 32-bit divide/modulo op through the two AXI-stream divider IPs: div_gen_signed and div_gen_unsigned.
- Sits between EXE issue logic and the divider IPs.
- Latches operands, handshakes each IP input channel independently, waits for dout, and returns the result over a valid/ready interface.
- Handles pipeline flush (exception/ertn) mid-operation by draining orphaned IP results so the IP never returns a stale value to a later op.

Parameters:
TIMEOUT_CYC, 64, cycles allowed in WAIT/DRAIN before the sticky timeout flag sets
CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous, active-low reset
req_valid  in  1  op request from EXE
req_ready  out  1  controller can accept an op
req_signed  in  1  1 = signed IP, 0 = unsigned IP
req_mod  in  1  1 = return remainder, 0 = return quotient
req_src1  in  32  dividend
req_src2  in  32  divisor
flush  in  1  cancel any op in flight; result is never delivered
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  32  quotient or remainder
s_dividend_tvalid, s_divisor_tvalid  out  1 each  signed IP input valids
s_dividend_tready, s_divisor_tready  in  1 each  signed IP input readies
u_dividend_tvalid, u_divisor_tvalid  out  1 each  unsigned IP input valids
u_dividend_tready, u_divisor_tready  in  1 each  unsigned IP input readies
div_dividend, div_divisor  out  32 each  latched operands, shared by both IPs
s_dout_valid  in  1  signed IP result valid
s_dout  in  64  signed IP result
u_dout_valid  in  1  unsigned IP result valid
u_dout  in  64  unsigned IP result
timeout  out  1  sticky: a wait exceeded TIMEOUT_CYC

Behaviour:
- Reset (async, resetn=0): state=IDLE, all tvalids=0, res_valid=0, res_data=0, timeout=0, operand/select registers=0, acceptance flags cleared, cancel flag cleared, counter=0. req_ready=1 in IDLE, so it reads 1 during and after reset.
- req_ready = (state==IDLE). Outputs res_valid and tvalids are registers or pure decodes of state/flags, never combinational from inputs.
- IDLE: on req_valid & !flush, latch src1, src2, signed, mod; clear dvd_acc, dvs_acc, cancel; go to ISSUE next cycle.
- ISSUE:
  - Only the selected IP's tvalids may assert; the other IP's tvalids stay 0.
  - dividend tvalid = !dvd_acc; divisor tvalid = !dvs_acc.
  - An acc flag sets on its valid&ready cycle; channels may complete in different cycles.
  - When both are accepted (registered flags or this-cycle handshake), go to WAIT, or to DRAIN if cancel is set.
- flush in ISSUE:
  - If no channel has been accepted yet (including this cycle), go to IDLE immediately.
  - Otherwise set cancel and finish issuing the remaining channel, then DRAIN. A half-issued op would wedge the IP.
- WAIT: on the selected dout_valid, capture res_data = mod ? dout[31:0] : dout[63:32] and go to DONE. flush (including the same cycle as dout_valid) goes to IDLE with the result discarded if dout_valid=1, else to DRAIN.
- DRAIN: on the selected dout_valid, go to IDLE; data discarded, res_valid stays 0. flush is ignored.
- DONE: res_valid=1; res_data holds stable until res_ready. res_ready goes to IDLE. flush goes to IDLE and drops the result. Simultaneous flush & res_ready counts as a flush; the consumer must ignore it.
- Counter:
  - Clears on entry to WAIT/DRAIN and increments each cycle in WAIT/DRAIN, saturating at all-ones.
  - timeout sets when the counter reaches TIMEOUT_CYC and clears only on reset. The state machine continues waiting.
- Divide-by-zero is not special-cased: whatever the IP returns is passed through.
- Exactly one op in flight; a new request is accepted only in IDLE, so back-to-back throughput is one op per (latency+2) cycles minimum.
- resetn asserted mid-op: the controller returns to IDLE asynchronously. IP state is the IP's concern; the IPs share the same reset domain.

Test Plan:
- Signed quotient: req src1=-7 (0xFFFFFFF9), src2=2, signed=1, mod=0; IP model with 8-cycle latency → s_*_tvalid for 1 cycle, u_* stay 0, res_valid with res_data=0xFFFFFFFD (-3), held until res_ready.
- Unsigned remainder with staggered readies: src1=100, src2=7, signed=0, mod=1; u_dividend_tready one cycle before u_divisor_tready → each tvalid drops after its own handshake, res_data=2.
- Flush in WAIT: signed op issued, flush 3 cycles later → DRAIN, no res_valid on IP dout. Next op 20/3 unsigned quotient returns 6, not the stale value.
- Flush in ISSUE with the divisor accepted but not the dividend → dividend still handshakes, then DRAIN. flush before any acceptance → IDLE the next cycle, no tvalid afterwards.
- Backpressure plus flush in DONE: res_ready=0 for 5 cycles → res_valid/res_data stable. Then flush → res_valid=0 next cycle, req_ready=1.
- Timeout and async reset: IP never asserts dout_valid → timeout=1 after 64 WAIT cycles, still in WAIT. Async resetn pulse mid-WAIT → all outputs at reset values without a clock edge, timeout=0.
